// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared FSM encoding, datapath width and sizing helper for the
//               neuron layer sequencer. NN_BIAS_EN adds one bias term/neuron.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int DATA_W = 24;

`ifdef NN_BIAS_EN
    localparam int BIAS_TERMS = 1;
`else
    localparam int BIAS_TERMS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ACT   = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-MODULUS up counter with sync clear, enable and
//               terminal-count flag (high while count == MODULUS-1).
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int MODULUS = 4,
    parameter int WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == C_LAST) ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_layer_sequencer
// Description : Sequences address/control strobes for one dense layer pass.
//               Define NN_BIAS_EN to append a bias term (adds bias_sel port).
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter  int N_IN   = 4,
    parameter  int N_OUT  = 3,
    localparam int STRIDE = N_IN + BIAS_TERMS,
    localparam int XW     = clog2_min1(N_IN),
    localparam int WW     = clog2_min1(N_OUT * STRIDE),
    localparam int YW     = clog2_min1(N_OUT)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          act_en,
    output logic          y_we,
    output logic [YW-1:0] y_addr,
    output logic          busy,
`ifdef NN_BIAS_EN
    output logic          bias_sel,
`endif
    output logic          done
);

    localparam int TW = clog2_min1(STRIDE);

    state_t          r_state;
    state_t          w_next;
    logic            r_acc_en;
    logic            r_done;
    logic            w_rst;
    logic [TW-1:0]   w_term;
    logic            w_term_tc;
    logic [YW-1:0]   w_neur;
    logic            w_neur_tc;
    logic            w_in_mac;
    logic [WW-1:0]   w_wsum;

    assign w_rst    = ~reset;
    assign w_in_mac = (r_state == ST_MAC);

    wrap_counter #(
        .MODULUS (STRIDE),
        .WIDTH   (TW)
    ) u_term_cnt (
        .clk     (CLK),
        .rst     (w_rst),
        .i_clr   (!w_in_mac),
        .i_en    (w_in_mac),
        .o_count (w_term),
        .o_tc    (w_term_tc)
    );

    wrap_counter #(
        .MODULUS (N_OUT),
        .WIDTH   (YW)
    ) u_neuron_cnt (
        .clk     (CLK),
        .rst     (w_rst),
        .i_clr   (r_state == ST_IDLE),
        .i_en    (r_state == ST_WRITE),
        .o_count (w_neur),
        .o_tc    (w_neur_tc)
    );

    // acc_en trails each MAC address cycle by one to cover memory read latency
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_acc_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_acc_en <= w_in_mac;
            r_done   <= (r_state == ST_WRITE) && w_neur_tc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_MAC;
            ST_MAC:   if (w_term_tc) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_ACT;
            ST_ACT:   w_next = ST_WRITE;
            ST_WRITE: w_next = w_neur_tc ? ST_IDLE : ST_CLEAR;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_wsum = WW'(int'(w_neur) * STRIDE + int'(w_term));

`ifdef NN_BIAS_EN
    logic r_bias_sel;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_bias_sel <= 1'b0;
        end else begin
            r_bias_sel <= w_in_mac && w_term_tc;
        end
    end

    assign bias_sel = r_bias_sel;
    // bias term reads no input sample, so hold x_addr at 0 during it
    assign x_addr   = (w_in_mac && !w_term_tc) ? XW'(w_term) : '0;
`else
    assign x_addr   = w_in_mac ? XW'(w_term) : '0;
`endif

    assign w_addr   = w_in_mac ? w_wsum : '0;
    assign acc_clr  = (r_state == ST_CLEAR);
    assign acc_en   = r_acc_en;
    assign act_en   = (r_state == ST_ACT);
    assign y_we     = (r_state == ST_WRITE);
    assign y_addr   = (r_state == ST_WRITE) ? w_neur : '0;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire
